// File: rtl/sg_read_req_splitter_64.sv
// Splits scatter-gather elements into PCIe memory reads bounded by MRRS, 4 KB pages, element and transfer length.
// First REQ >= 3 cycles after TXN_START; REQ holds until REQ_ACK, next REQ on the same element 2 cycles after the ack.
module sg_read_req_splitter_64 #(
   parameter int C_MAX_REQ_WORDS = 1024
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        TXN_START,
   input  logic [31:0] TXN_LEN,
   input  logic [2:0]  CONFIG_MAX_READ_REQUEST_SIZE,
   input  logic        SG_VALID,
   input  logic        SG_EMPTY,
   output logic        SG_REN,
   input  logic [63:0] SG_ADDR,
   input  logic [31:0] SG_LEN,
   output logic        REQ,
   input  logic        REQ_ACK,
   output logic [63:0] REQ_ADDR,
   output logic [10:0] REQ_LEN,
   output logic        BUSY,
   output logic        DONE
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_CALC,
      S_ISSUE,
      S_FIN
   } state_t;

   localparam logic [31:0] MAX_WORDS = 32'(C_MAX_REQ_WORDS);

   state_t      state;
   logic [63:0] cur_addr;
   logic [31:0] elem_rem;
   logic [31:0] txn_rem;
   logic        fetch_hold;

   logic [2:0]  mrrs_enc;
   logic [31:0] mrrs_words;
   logic [31:0] bnd_words;
   logic [31:0] len_c;
   logic [31:0] issue_len;

   // Request length is the smallest of all five limits; each limit is at least 1.
   always_comb begin
      mrrs_enc   = (CONFIG_MAX_READ_REQUEST_SIZE > 3'd5) ? 3'd5 : CONFIG_MAX_READ_REQUEST_SIZE;
      mrrs_words = 32'd32 << mrrs_enc;
      bnd_words  = 32'd1024 - {22'd0, cur_addr[11:2]};
      len_c      = elem_rem;
      if (txn_rem < len_c) begin
         len_c = txn_rem;
      end
      if (mrrs_words < len_c) begin
         len_c = mrrs_words;
      end
      if (bnd_words < len_c) begin
         len_c = bnd_words;
      end
      if (MAX_WORDS < len_c) begin
         len_c = MAX_WORDS;
      end
   end

   assign issue_len = {21'd0, REQ_LEN};

   logic unused_sigs;
   assign unused_sigs = &{1'b0, SG_EMPTY, SG_ADDR[1:0], len_c[31:11]};

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= S_IDLE;
         cur_addr   <= 64'd0;
         elem_rem   <= 32'd0;
         txn_rem    <= 32'd0;
         fetch_hold <= 1'b0;
         SG_REN     <= 1'b0;
         REQ        <= 1'b0;
         REQ_ADDR   <= 64'd0;
         REQ_LEN    <= 11'd0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
      end else begin
         SG_REN <= 1'b0;
         DONE   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (TXN_START) begin
                  txn_rem <= TXN_LEN;
                  BUSY    <= 1'b1;
                  state   <= (TXN_LEN == 32'd0) ? S_FIN : S_FETCH;
               end
            end
            S_FETCH: begin
               // Upstream VALID lags SG_REN by a cycle, so skip sampling right after a pop.
               if (fetch_hold) begin
                  fetch_hold <= 1'b0;
               end else if (SG_VALID) begin
                  cur_addr <= {SG_ADDR[63:2], 2'b00};
                  elem_rem <= SG_LEN;
                  SG_REN   <= 1'b1;
                  if (SG_LEN == 32'd0) begin
                     fetch_hold <= 1'b1;
                  end else begin
                     state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               REQ_ADDR <= cur_addr;
               REQ_LEN  <= len_c[10:0];
               REQ      <= 1'b1;
               state    <= S_ISSUE;
            end
            S_ISSUE: begin
               if (REQ_ACK) begin
                  REQ      <= 1'b0;
                  cur_addr <= cur_addr + {30'd0, issue_len, 2'b00};
                  elem_rem <= elem_rem - issue_len;
                  txn_rem  <= txn_rem - issue_len;
                  if (txn_rem == issue_len) begin
                     state <= S_FIN;
                  end else if (elem_rem == issue_len) begin
                     state <= S_FETCH;
                  end else begin
                     state <= S_CALC;
                  end
               end
            end
            S_FIN: begin
               DONE  <= 1'b1;
               BUSY  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sg_read_req_splitter_64.sv
// Bench for sg_read_req_splitter_64: SG source with late VALID drop, random REQ_ACK, plan vectors and a random model.
module tb_sg_read_req_splitter_64;

   logic        CLK;
   logic        RST;
   logic        TXN_START;
   logic [31:0] TXN_LEN;
   logic [2:0]  CONFIG_MAX_READ_REQUEST_SIZE;
   logic        SG_VALID;
   logic        SG_EMPTY;
   logic        SG_REN;
   logic [63:0] SG_ADDR;
   logic [31:0] SG_LEN;
   logic        REQ;
   logic        REQ_ACK;
   logic [63:0] REQ_ADDR;
   logic [10:0] REQ_LEN;
   logic        BUSY;
   logic        DONE;

   sg_read_req_splitter_64 #(.C_MAX_REQ_WORDS(1024)) dut (
      .CLK(CLK), .RST(RST), .TXN_START(TXN_START), .TXN_LEN(TXN_LEN),
      .CONFIG_MAX_READ_REQUEST_SIZE(CONFIG_MAX_READ_REQUEST_SIZE),
      .SG_VALID(SG_VALID), .SG_EMPTY(SG_EMPTY), .SG_REN(SG_REN),
      .SG_ADDR(SG_ADDR), .SG_LEN(SG_LEN), .REQ(REQ), .REQ_ACK(REQ_ACK),
      .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN), .BUSY(BUSY), .DONE(DONE)
   );

   typedef struct packed {
      logic [63:0] addr;
      logic [31:0] len;
   } elem_t;

   typedef struct packed {
      logic [63:0] addr;
      logic [10:0] len;
   } req_t;

   elem_t sg_q[$];
   req_t  got_q[$];
   req_t  exp_q[$];
   int    n_checks = 0;
   int    n_fail = 0;
   int    ren_cnt = 0;
   int    done_cnt = 0;
   int    ack_pct = 50;
   bit    busy_at_done = 1'b1;
   bit    pop_pending = 1'b0;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Upstream SG reader: pops on SG_REN, but only updates VALID/data one clock later.
   initial begin
      SG_VALID = 1'b0;
      SG_ADDR  = 64'd0;
      SG_LEN   = 32'd0;
      SG_EMPTY = 1'b1;
      forever begin
         @(posedge CLK);
         #1;
         if (pop_pending) begin
            if (sg_q.size() > 0) void'(sg_q.pop_front());
            pop_pending = 1'b0;
         end
         SG_VALID = (sg_q.size() > 0);
         SG_EMPTY = (sg_q.size() == 0);
         if (sg_q.size() > 0) begin
            SG_ADDR = sg_q[0].addr;
            SG_LEN  = sg_q[0].len;
         end
      end
   end

   // Monitor and acker: a handshake is recorded when the ack chosen now meets REQ held to the next edge.
   initial begin
      REQ_ACK = 1'b0;
      forever begin
         @(negedge CLK);
         if (SG_REN) begin
            ren_cnt++;
            pop_pending = 1'b1;
         end
         if (DONE) begin
            done_cnt++;
            busy_at_done = BUSY;
         end
         REQ_ACK = (int'($urandom_range(99, 0)) < ack_pct);
         if (REQ && REQ_ACK && !RST) got_q.push_back({REQ_ADDR, REQ_LEN});
      end
   end

   task automatic start_txn(input logic [31:0] len, input logic [2:0] enc);
      got_q.delete();
      ren_cnt = 0;
      done_cnt = 0;
      busy_at_done = 1'b1;
      CONFIG_MAX_READ_REQUEST_SIZE = enc;
      @(negedge CLK);
      TXN_LEN = len;
      TXN_START = 1'b1;
      @(negedge CLK);
      TXN_START = 1'b0;
   endtask

   task automatic wait_done(output bit timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < 20000; i++) begin
         if (done_cnt > 0) begin
            timed_out = 1'b0;
            break;
         end
         @(negedge CLK);
      end
      repeat (6) @(negedge CLK);
   endtask

   task automatic test_reset();
      RST = 1'b1;
      TXN_START = 1'b1;
      TXN_LEN = 32'd5;
      CONFIG_MAX_READ_REQUEST_SIZE = 3'd0;
      repeat (3) @(negedge CLK);
      n_checks++;
      if ({REQ, SG_REN, BUSY, DONE, REQ_ADDR, REQ_LEN} !== 79'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got REQ=%b REN=%b BUSY=%b DONE=%b ADDR=%h LEN=%0d expected all zero",
                  REQ, SG_REN, BUSY, DONE, REQ_ADDR, REQ_LEN);
      end
      TXN_START = 1'b0;
      RST = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle_busy: got %b expected 0", BUSY);
      end
   endtask

   task automatic test_basic();
      bit to;
      sg_q.delete(); pop_pending = 1'b0;
      sg_q.push_back({64'h1000, 32'd100});
      exp_q.delete();
      exp_q.push_back({64'h1000, 11'd32}); exp_q.push_back({64'h1080, 11'd32});
      exp_q.push_back({64'h1100, 11'd32}); exp_q.push_back({64'h1180, 11'd4});
      ack_pct = 50;
      start_txn(32'd100, 3'd0);
      wait_done(to);
      n_checks++;
      if (to !== 1'b0 || done_cnt != 1 || ren_cnt != 1) begin
         n_fail++;
         $display("FAIL basic_ctrl: got timeout=%b done=%0d ren=%0d expected 0/1/1", to, done_cnt, ren_cnt);
      end
      n_checks++;
      if (got_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL basic_count: got %0d requests expected %0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         n_checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL basic_req%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 75'd0, exp_q[i]);
         end
      end
   endtask

   task automatic test_4k_boundary();
      bit to;
      sg_q.delete(); pop_pending = 1'b0;
      sg_q.push_back({64'h0FF8, 32'd16});
      exp_q.delete();
      exp_q.push_back({64'h0FF8, 11'd2}); exp_q.push_back({64'h1000, 11'd14});
      start_txn(32'd16, 3'd5);
      wait_done(to);
      n_checks++;
      if (to !== 1'b0 || done_cnt != 1 || ren_cnt != 1) begin
         n_fail++;
         $display("FAIL bnd_ctrl: got timeout=%b done=%0d ren=%0d expected 0/1/1", to, done_cnt, ren_cnt);
      end
      n_checks++;
      if (got_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL bnd_count: got %0d requests expected %0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         n_checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL bnd_req%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 75'd0, exp_q[i]);
         end
      end
   endtask

   task automatic test_zero_elem();
      bit to;
      sg_q.delete(); pop_pending = 1'b0;
      sg_q.push_back({64'h2000, 32'd8});
      sg_q.push_back({64'h0, 32'd0});
      sg_q.push_back({64'h9000, 32'd8});
      exp_q.delete();
      exp_q.push_back({64'h2000, 11'd8}); exp_q.push_back({64'h9000, 11'd8});
      start_txn(32'd16, 3'd2);
      wait_done(to);
      n_checks++;
      if (to !== 1'b0 || done_cnt != 1 || ren_cnt != 3) begin
         n_fail++;
         $display("FAIL zelem_ctrl: got timeout=%b done=%0d ren=%0d expected 0/1/3", to, done_cnt, ren_cnt);
      end
      n_checks++;
      if (got_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL zelem_count: got %0d requests expected %0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         n_checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL zelem_req%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 75'd0, exp_q[i]);
         end
      end
   endtask

   task automatic test_short_txn();
      bit to;
      sg_q.delete(); pop_pending = 1'b0;
      sg_q.push_back({64'h3000, 32'd50});
      sg_q.push_back({64'h7000, 32'd50});
      start_txn(32'd10, 3'd3);
      wait_done(to);
      n_checks++;
      if (to !== 1'b0 || done_cnt != 1 || ren_cnt != 1 || busy_at_done !== 1'b0) begin
         n_fail++;
         $display("FAIL short_ctrl: got timeout=%b done=%0d ren=%0d busy_at_done=%b expected 0/1/1/0",
                  to, done_cnt, ren_cnt, busy_at_done);
      end
      n_checks++;
      if (got_q.size() != 1 || got_q[0] !== {64'h3000, 11'd10}) begin
         n_fail++;
         $display("FAIL short_req: got %0d requests first %h expected 1 request %h",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : 75'd0, {64'h3000, 11'd10});
      end
   endtask

   task automatic test_carry();
      bit to;
      sg_q.delete(); pop_pending = 1'b0;
      sg_q.push_back({64'h0000_0000_FFFF_FFC0, 32'd64});
      exp_q.delete();
      exp_q.push_back({64'h0000_0000_FFFF_FFC0, 11'd16});
      exp_q.push_back({64'h0000_0001_0000_0000, 11'd48});
      start_txn(32'd64, 3'd1);
      wait_done(to);
      n_checks++;
      if (to !== 1'b0 || done_cnt != 1 || ren_cnt != 1) begin
         n_fail++;
         $display("FAIL carry_ctrl: got timeout=%b done=%0d ren=%0d expected 0/1/1", to, done_cnt, ren_cnt);
      end
      n_checks++;
      if (got_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL carry_count: got %0d requests expected %0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         n_checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL carry_req%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 75'd0, exp_q[i]);
         end
      end
   endtask

   task automatic test_hold();
      bit to;
      bit stable;
      logic [63:0] a0;
      logic [10:0] l0;
      sg_q.delete(); pop_pending = 1'b0;
      sg_q.push_back({64'h1000, 32'd100});
      ack_pct = 0;
      start_txn(32'd100, 3'd0);
      for (int i = 0; i < 50 && !REQ; i++) @(negedge CLK);
      a0 = REQ_ADDR;
      l0 = REQ_LEN;
      n_checks++;
      if (REQ !== 1'b1 || a0 !== 64'h1000 || l0 !== 11'd32) begin
         n_fail++;
         $display("FAIL hold_first: got REQ=%b %h/%0d expected 1 00001000/32", REQ, a0, l0);
      end
      stable = 1'b1;
      repeat (20) begin
         @(negedge CLK);
         if (REQ !== 1'b1 || REQ_ADDR !== a0 || REQ_LEN !== l0) stable = 1'b0;
      end
      n_checks++;
      if (stable !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_stable: got %b expected 1 (REQ=%b %h/%0d)", stable, REQ, REQ_ADDR, REQ_LEN);
      end
      ack_pct = 60;
      wait_done(to);
      n_checks++;
      if (to !== 1'b0 || done_cnt != 1 || got_q.size() != 4) begin
         n_fail++;
         $display("FAIL hold_finish: got timeout=%b done=%0d reqs=%0d expected 0/1/4", to, done_cnt, got_q.size());
      end
      ack_pct = 50;
   endtask

   task automatic test_rst_mid();
      sg_q.delete(); pop_pending = 1'b0;
      sg_q.push_back({64'h4000, 32'd200});
      ack_pct = 0;
      start_txn(32'd200, 3'd2);
      for (int i = 0; i < 50 && !REQ; i++) @(negedge CLK);
      n_checks++;
      if (REQ !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_req: got %b expected 1", REQ);
      end
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      n_checks++;
      if (REQ !== 1'b0 || BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_abort: got REQ=%b BUSY=%b expected 0/0", REQ, BUSY);
      end
      ack_pct = 50;
      repeat (10) @(negedge CLK);
      n_checks++;
      if (done_cnt != 0 || REQ !== 1'b0 || ren_cnt != 1) begin
         n_fail++;
         $display("FAIL rstmid_after: got done=%0d REQ=%b ren=%0d expected 0/0/1", done_cnt, REQ, ren_cnt);
      end
   endtask

   task automatic test_zero_txn();
      logic d0, b0, d1, b1, d2;
      sg_q.delete(); pop_pending = 1'b0;
      sg_q.push_back({64'h5000, 32'd8});
      got_q.delete();
      ren_cnt = 0;
      done_cnt = 0;
      @(negedge CLK);
      TXN_LEN = 32'd0;
      TXN_START = 1'b1;
      @(negedge CLK);
      TXN_START = 1'b0;
      d0 = DONE; b0 = BUSY;
      @(negedge CLK);
      d1 = DONE; b1 = BUSY;
      @(negedge CLK);
      d2 = DONE;
      repeat (5) @(negedge CLK);
      n_checks++;
      if ({d0, b0, d1, b1, d2} !== 5'b01100) begin
         n_fail++;
         $display("FAIL zerotxn_timing: got DONE/BUSY %b%b %b%b %b expected 01 10 0", d0, b0, d1, b1, d2);
      end
      n_checks++;
      if (ren_cnt != 0 || got_q.size() != 0 || done_cnt != 1) begin
         n_fail++;
         $display("FAIL zerotxn_side: got ren=%0d reqs=%0d done=%0d expected 0/0/1", ren_cnt, got_q.size(), done_cnt);
      end
   endtask

   // Random transfers against a page/MRRS/length model; also runs transfers back to back.
   task automatic test_random();
      elem_t       elems[$];
      bit          to;
      logic [31:0] txn, sum, e, t, l, m, b, len;
      logic [63:0] a;
      logic [2:0]  enc;
      int          exp_ren;
      for (int n = 0; n < 15; n++) begin
         sg_q.delete(); pop_pending = 1'b0;
         txn = $urandom_range(1500, 1);
         enc = 3'($urandom_range(7, 0));
         sum = 0;
         while (sum <= txn) begin
            a = {$urandom, $urandom};
            if ($urandom_range(3, 0) == 0) a[31:0] = 32'hFFFF_F000 | 32'($urandom_range(4095, 0));
            len = ($urandom_range(4, 0) == 0) ? 32'd0 : 32'($urandom_range(300, 1));
            sg_q.push_back({a, len});
            sum += len;
         end
         elems = sg_q;
         exp_q.delete();
         exp_ren = 0;
         t = txn;
         foreach (elems[k]) begin
            if (t == 0) break;
            exp_ren++;
            a = elems[k].addr & ~64'h3;
            e = elems[k].len;
            while (e > 0 && t > 0) begin
               m = 32'd32 << ((enc > 3'd5) ? 3'd5 : enc);
               b = (32'd4096 - 32'(a % 64'd4096)) / 32'd4;
               l = e;
               if (t < l) l = t;
               if (m < l) l = m;
               if (b < l) l = b;
               if (32'd1024 < l) l = 32'd1024;
               exp_q.push_back({a, l[10:0]});
               a += 64'(l) * 64'd4;
               e -= l;
               t -= l;
            end
         end
         ack_pct = int'($urandom_range(90, 20));
         start_txn(txn, enc);
         wait_done(to);
         n_checks++;
         if (to !== 1'b0 || done_cnt != 1 || ren_cnt != exp_ren || busy_at_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rand%0d_ctrl: got timeout=%b done=%0d ren=%0d busy_at_done=%b expected 0/1/%0d/0",
                     n, to, done_cnt, ren_cnt, busy_at_done, exp_ren);
         end
         n_checks++;
         if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand%0d_count: got %0d requests expected %0d", n, got_q.size(), exp_q.size());
         end
         foreach (exp_q[i]) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
               n_fail++;
               $display("FAIL rand%0d_req%0d: got %h expected %h", n, i,
                        (i < got_q.size()) ? got_q[i] : 75'd0, exp_q[i]);
            end
         end
      end
      ack_pct = 50;
   endtask

   initial begin
      RST = 1'b1;
      TXN_START = 1'b0;
      TXN_LEN = 32'd0;
      CONFIG_MAX_READ_REQUEST_SIZE = 3'd0;
      test_reset();
      test_basic();
      test_4k_boundary();
      test_zero_elem();
      test_short_txn();
      test_carry();
      test_hold();
      test_rst_mid();
      test_zero_txn();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sg_read_req_splitter_64.md
Name: sg_read_req_splitter_64

Overview:
- Consumes scatter-gather elements (64-bit address, 32-bit word length) from the upstream SG list reader.
- Splits them into PCIe memory-read requests for an RX transfer.
- Each request is bounded by the max read request size, the 4 KB address boundary, the remaining element length and the remaining transfer length.
- Sits between the SG list reader and the RX requester/TX engine arbitration mux.

Parameters:
- C_MAX_REQ_WORDS, 1024: hard cap on a single request length in 32-bit words; must be a power of two, 32..1024.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- TXN_START  in  1  one-cycle pulse; starts a transfer
- TXN_LEN  in  32  total words to request; sampled on TXN_START
- CONFIG_MAX_READ_REQUEST_SIZE  in  3  PCIe encoding: 0=128B, 1=256B, 2=512B, 3=1KB, 4=2KB, 5=4KB; 6 and 7 treated as 5
- SG_VALID  in  1  SG element ADDR/LEN valid
- SG_EMPTY  in  1  SG list empty (status only; does not gate fetching)
- SG_REN  out  1  one-cycle pulse; consumes the presented element
- SG_ADDR  in  64  element byte address
- SG_LEN  in  32  element length in words
- REQ  out  1  read request valid
- REQ_ACK  in  1  request accepted this cycle
- REQ_ADDR  out  64  request byte address; bits [1:0] are always 0
- REQ_LEN  out  11  request length in words, 1..1024
- BUSY  out  1  transfer in progress
- DONE  out  1  one-cycle pulse when all TXN_LEN words have been requested

Behaviour:
Decided: one clock; reset is synchronous and active-high (CLK, RST).
- Reset: all outputs 0; state IDLE; internal address and counters cleared. RST mid-transfer aborts immediately, with REQ low on the next cycle; no DONE is pulsed.
- All outputs are registered.
- States:
  - IDLE: on TXN_START, latch txn_rem=TXN_LEN and BUSY<=1. If TXN_LEN==0, go to FIN; else go to FETCH. TXN_START outside IDLE is ignored.
  - FETCH: wait for SG_VALID. When it is seen:
    - Latch cur_addr={SG_ADDR[63:2],2'b00} and elem_rem=SG_LEN.
    - Pulse SG_REN for exactly 1 cycle.
    - If SG_LEN==0, stay in FETCH (element dropped, no request). Do not sample SG_VALID in the cycle immediately after SG_REN, because upstream VALID deasserts one cycle late.
    - Otherwise go to CALC.
  - CALC (1 cycle): compute len = min(elem_rem, txn_rem, mrrs_words, bnd_words, C_MAX_REQ_WORDS).
    - mrrs_words = 32<<enc.
    - bnd_words = 1024 - cur_addr[11:2], range 1..1024.
    - Register REQ_ADDR=cur_addr and REQ_LEN=len; go to ISSUE.
  - ISSUE: hold REQ=1 with stable REQ_ADDR/REQ_LEN until REQ_ACK. On the ack cycle, REQ<=0 and update:
    - cur_addr += len*4 (64-bit add, carry across bit 32 required)
    - elem_rem -= len
    - txn_rem -= len
    - Next state: if txn_rem==len, FIN; else if elem_rem==len, FETCH; else CALC.
  - FIN: pulse DONE for 1 cycle, BUSY<=0, go to IDLE. Any unrequested remainder of the current element is discarded; the element is not re-read.
- Latency:
  - TXN_START to first REQ: at least 3 cycles (IDLE to FETCH, FETCH capture, CALC).
  - REQ_ACK to next REQ on the same element: 2 cycles.
- REQ_ACK while REQ=0 is ignored.
- CONFIG_MAX_READ_REQUEST_SIZE is re-sampled in every CALC.
- The request never crosses a 4 KB boundary; each of REQ_LEN's terms is ≥ 1, so REQ_LEN ≥ 1.
- If SG_VALID never arrives, FETCH waits indefinitely; there is no timeout.

Test Plan:
- TXN_LEN=100, one element ADDR=0x1000 LEN=100, MRRS=0 (32 words) -> REQ 0x1000/32, 0x1080/32, 0x1100/32, 0x1180/4; DONE once; one SG_REN pulse.
- Element ADDR=0x0FF8 LEN=16, TXN_LEN=16, MRRS=5 -> REQ 0x0FF8/2, then 0x1000/14.
- Elements (0x2000,8), (0x0,0), (0x9000,8), TXN_LEN=16 -> REQs 0x2000/8 and 0x9000/8; three SG_REN pulses; zero-length element produces no REQ.
- TXN_LEN=10, element LEN=50 -> single REQ len 10; DONE; exactly one SG_REN; BUSY falls with DONE.
- ADDR=0x0000_0000_FFFF_FFC0 LEN=64, MRRS=1 -> REQ 0x..FFC0/16, then 0x0000_0001_0000_0000/48 (carry into upper word).
- REQ_ACK held low 20 cycles -> REQ/ADDR/LEN stable throughout; RST asserted during ISSUE -> REQ=0, BUSY=0, no DONE; TXN_LEN=0 -> DONE 2 cycles after TXN_START with no SG_REN or REQ.
